// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: forwarding codes, ALU control
// encodings and default datapath widths.
package cpu_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int REGBITS_DEF = 5;
  localparam int CTRLW_DEF   = 3;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_REG;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_forward_unit.sv
// RAW hazard comparator: selects the forwarding source for each EX operand
// from the MEM and WB stage destinations.
module forward_unit
  import cpu_pkg::*;
#(
  parameter int REGBITS = REGBITS_DEF
) (
  input  logic [REGBITS-1:0] rs_e,
  input  logic [REGBITS-1:0] rt_e,
  input  logic               m_regwrite,
  input  logic [REGBITS-1:0] m_writereg,
  input  logic               w_regwrite,
  input  logic [REGBITS-1:0] w_writereg,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  logic m_live, w_live;

  // Register 0 is hardwired, so a write to it never produces a forwardable value.
  assign m_live = m_regwrite && (m_writereg != '0);
  assign w_live = w_regwrite && (w_writereg != '0);

  assign fwd_a = fwd_sel(m_live && (m_writereg == rs_e), w_live && (w_writereg == rs_e));
  assign fwd_b = fwd_sel(m_live && (m_writereg == rt_e), w_live && (w_writereg == rt_e));

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand forwarding for the MIPS core.
// Optional FWD_STATS_EN adds a saturating forwarded-cycle counter (fwd_count).
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REGBITS = REGBITS_DEF,
  parameter int CTRLW   = CTRLW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic               d_valid,
  input  logic [WIDTH-1:0]   d_rd1,
  input  logic [WIDTH-1:0]   d_rd2,
  input  logic [REGBITS-1:0] d_rs,
  input  logic [REGBITS-1:0] d_rt,
  input  logic [REGBITS-1:0] d_rd,
  input  logic [WIDTH-1:0]   d_imm,
  input  logic [CTRLW-1:0]   d_alu_ctrl,
  input  logic               d_alusrc,
  input  logic               d_regdst,
  input  logic               d_regwrite,
  input  logic               d_memtoreg,
  input  logic               d_memwrite,
  input  logic               m_regwrite,
  input  logic [REGBITS-1:0] m_writereg,
  input  logic [WIDTH-1:0]   m_aluout,
  input  logic               w_regwrite,
  input  logic [REGBITS-1:0] w_writereg,
  input  logic [WIDTH-1:0]   w_result,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [CTRLW-1:0]   alu_ctrl,
  output logic [WIDTH-1:0]   e_writedata,
  output logic [REGBITS-1:0] e_writereg,
  output logic               e_regwrite,
  output logic               e_memtoreg,
  output logic               e_memwrite,
  output logic               e_valid,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]        fwd_count
`endif
);

  logic               valid_e;
  logic [WIDTH-1:0]   rd1_e, rd2_e, imm_e;
  logic [REGBITS-1:0] rs_e, rt_e, rd_e;
  logic [CTRLW-1:0]   alu_ctrl_e;
  logic               alusrc_e, regdst_e, regwrite_e, memtoreg_e, memwrite_e;
  logic [WIDTH-1:0]   src_a, src_b;

  forward_unit #(.REGBITS(REGBITS)) u_fwd (
    .rs_e       (rs_e),
    .rt_e       (rt_e),
    .m_regwrite (m_regwrite),
    .m_writereg (m_writereg),
    .w_regwrite (w_regwrite),
    .w_writereg (w_writereg),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always_comb begin
    src_a = rd1_e;
    case (fwd_a)
      FWD_MEM: src_a = m_aluout;
      FWD_WB:  src_a = w_result;
      default: src_a = rd1_e;
    endcase
  end

  always_comb begin
    src_b = rd2_e;
    case (fwd_b)
      FWD_MEM: src_b = m_aluout;
      FWD_WB:  src_b = w_result;
      default: src_b = rd2_e;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      alu_ctrl_e <= '0;
      alusrc_e   <= 1'b0;
      regdst_e   <= 1'b0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0;
    end else if (stall_e) begin
      // Capture forwarded values so a producer leaving WB mid-stall is not lost.
      rd1_e <= src_a;
      rd2_e <= src_b;
    end else begin
      valid_e    <= d_valid;
      rd1_e      <= d_rd1;
      rd2_e      <= d_rd2;
      imm_e      <= d_imm;
      rs_e       <= d_rs;
      rt_e       <= d_rt;
      rd_e       <= d_rd;
      alu_ctrl_e <= d_alu_ctrl;
      alusrc_e   <= d_alusrc;
      regdst_e   <= d_regdst;
      regwrite_e <= d_regwrite & d_valid;
      memtoreg_e <= d_memtoreg & d_valid;
      memwrite_e <= d_memwrite & d_valid;
    end
  end

  assign alu_a       = src_a;
  assign alu_b       = alusrc_e ? imm_e : src_b;
  assign alu_ctrl    = alu_ctrl_e;
  assign e_writedata = src_b;
  assign e_writereg  = regdst_e ? rd_e : rt_e;
  assign e_valid     = valid_e;
  assign e_regwrite  = regwrite_e;
  assign e_memtoreg  = memtoreg_e;
  assign e_memwrite  = memwrite_e;

`ifdef FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_count <= '0;
    end else if (valid_e && !stall_e && ((fwd_a != FWD_REG) || (fwd_b != FWD_REG))
                 && (fwd_count != 16'hFFFF)) begin
      fwd_count <= fwd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX outputs are queued as
// stimulus is applied and compared once the stage presents them.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e, d_valid;
  logic [31:0] d_rd1, d_rd2, d_imm, m_aluout, w_result;
  logic [4:0]  d_rs, d_rt, d_rd, m_writereg, w_writereg;
  logic [2:0]  d_alu_ctrl;
  logic        d_alusrc, d_regdst, d_regwrite, d_memtoreg, d_memwrite;
  logic        m_regwrite, w_regwrite;
  logic [31:0] alu_a, alu_b, e_writedata;
  logic [2:0]  alu_ctrl;
  logic [4:0]  e_writereg;
  logic        e_regwrite, e_memtoreg, e_memwrite, e_valid;
  logic [1:0]  fwd_a, fwd_b;
`ifdef FWD_STATS_EN
  logic [15:0] fwd_count;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wd;
    logic [2:0]  ctrl;
    logic [4:0]  wr;
    logic        v, rw, m2r, mw;
    logic [1:0]  fa, fb;
  } obs_t;

  obs_t sb[$];
  obs_t exp_o, got_o;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .d_valid(d_valid), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_rs(d_rs), .d_rt(d_rt),
    .d_rd(d_rd), .d_imm(d_imm), .d_alu_ctrl(d_alu_ctrl), .d_alusrc(d_alusrc),
    .d_regdst(d_regdst), .d_regwrite(d_regwrite), .d_memtoreg(d_memtoreg),
    .d_memwrite(d_memwrite), .m_regwrite(m_regwrite), .m_writereg(m_writereg),
    .m_aluout(m_aluout), .w_regwrite(w_regwrite), .w_writereg(w_writereg),
    .w_result(w_result), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .e_writedata(e_writedata), .e_writereg(e_writereg), .e_regwrite(e_regwrite),
    .e_memtoreg(e_memtoreg), .e_memwrite(e_memwrite), .e_valid(e_valid),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef FWD_STATS_EN
    , .fwd_count(fwd_count)
`endif
  );

  function automatic obs_t mk(input logic [31:0] a, b, wd, input logic [2:0] ctrl,
                              input logic [4:0] wr, input logic v, rw, m2r, mw,
                              input logic [1:0] fa, fb);
    return '{a, b, wd, ctrl, wr, v, rw, m2r, mw, fa, fb};
  endfunction

  function automatic obs_t sample();
    return '{alu_a, alu_b, e_writedata, alu_ctrl, e_writereg, e_valid,
             e_regwrite, e_memtoreg, e_memwrite, fwd_a, fwd_b};
  endfunction

  task automatic clear_inputs();
    stall_e = 0; flush_e = 0; d_valid = 0;
    d_rd1 = 0; d_rd2 = 0; d_imm = 0; d_rs = 0; d_rt = 0; d_rd = 0;
    d_alu_ctrl = 0; d_alusrc = 0; d_regdst = 0;
    d_regwrite = 0; d_memtoreg = 0; d_memwrite = 0;
    m_regwrite = 0; m_writereg = 0; m_aluout = 0;
    w_regwrite = 0; w_writereg = 0; w_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    d_valid = 1; d_alu_ctrl = 3'b110; d_regwrite = 1; d_memwrite = 1; d_rd1 = 32'h1234;
    sb.push_back(mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step();
    reset = 0;
    clear_inputs();
    #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", got_o, exp_o);
    end
`ifdef FWD_STATS_EN
    checks++;
    if (fwd_count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_count got=%h exp=0000", fwd_count);
    end
`endif
  endtask

  task automatic test_basic_load();
    clear_inputs();
    d_valid = 1; d_rd1 = 0; d_rd2 = 1; d_alu_ctrl = 3'b010; d_alusrc = 0;
    d_regdst = 1; d_rd = 8; d_rs = 1; d_rt = 2; d_regwrite = 1;
    sb.push_back(mk(0, 1, 1, 3'b010, 8, 1, 1, 0, 0, 2'b00, 2'b00));
    step(); #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL basic_load got=%h exp=%h", got_o, exp_o);
    end
    // rt destination, load flags
    d_regdst = 0; d_rt = 9; d_rd = 3; d_memtoreg = 1; d_alu_ctrl = 3'b111;
    d_rd1 = 32'hA5A5_0000; d_rd2 = 32'h0000_5A5A;
    sb.push_back(mk(32'hA5A5_0000, 32'h0000_5A5A, 32'h0000_5A5A, 3'b111, 9, 1, 1, 1, 0, 2'b00, 2'b00));
    step(); #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL load_rt_dest got=%h exp=%h", got_o, exp_o);
    end
    // invalid decode slot must not carry write/mem controls
    d_valid = 0; d_regwrite = 1; d_memwrite = 1; d_memtoreg = 1;
    d_alu_ctrl = 3'b010; d_rd1 = 7; d_rd2 = 6; d_rt = 5;
    sb.push_back(mk(7, 6, 6, 3'b010, 5, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL invalid_slot got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    d_valid = 1; d_rs = 3; d_rt = 5; d_rd1 = 32'h11; d_rd2 = 32'h22;
    d_alu_ctrl = 3'b010; d_regdst = 1; d_rd = 7; d_regwrite = 1;
    step();
    m_regwrite = 1; m_writereg = 3; m_aluout = 32'h55;
    w_regwrite = 1; w_writereg = 3; w_result = 32'h66;
    sb.push_back(mk(32'h55, 32'h22, 32'h22, 3'b010, 7, 1, 1, 0, 0, 2'b10, 2'b00));
    #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL fwd_mem_prio got=%h exp=%h", got_o, exp_o);
    end
    m_regwrite = 0;
    sb.push_back(mk(32'h66, 32'h22, 32'h22, 3'b010, 7, 1, 1, 0, 0, 2'b01, 2'b00));
    #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL fwd_wb got=%h exp=%h", got_o, exp_o);
    end
    m_regwrite = 1; m_writereg = 5;
    sb.push_back(mk(32'h66, 32'h55, 32'h55, 3'b010, 7, 1, 1, 0, 0, 2'b01, 2'b10));
    #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL fwd_split got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_reg0_imm();
    clear_inputs();
    d_valid = 1; d_rs = 0; d_rt = 4; d_rd1 = 32'hAA; d_rd2 = 32'hBB;
    d_alusrc = 1; d_imm = 32'hFFFF_FFFC; d_regdst = 0; d_memwrite = 1;
    d_alu_ctrl = 3'b010;
    step();
    m_regwrite = 1; m_writereg = 0; m_aluout = 32'h55;
    w_regwrite = 1; w_writereg = 4; w_result = 32'h77;
    sb.push_back(mk(32'hAA, 32'hFFFF_FFFC, 32'h77, 3'b010, 4, 1, 0, 0, 1, 2'b00, 2'b01));
    #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL reg0_imm got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_stall_retire();
    clear_inputs();
    d_valid = 1; d_rs = 1; d_rt = 4; d_rd1 = 32'h10; d_rd2 = 32'h20;
    d_regdst = 1; d_rd = 6; d_regwrite = 1; d_alu_ctrl = 3'b110;
    step();
    w_regwrite = 1; w_writereg = 4; w_result = 32'h99;
    sb.push_back(mk(32'h10, 32'h99, 32'h99, 3'b110, 6, 1, 1, 0, 0, 2'b00, 2'b01));
    #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL stall_pre got=%h exp=%h", got_o, exp_o);
    end
    stall_e = 1;
    d_rd1 = 32'hDEAD; d_rd2 = 32'hBEEF; d_rt = 9; d_rd = 12; d_alu_ctrl = 3'b001;
    for (int c = 1; c <= 2; c++) begin
      sb.push_back(mk(32'h10, 32'h99, 32'h99, 3'b110, 6, 1, 1, 0, 0, 2'b00, 2'b00));
      step();
      w_regwrite = 1; w_writereg = 13; w_result = 32'h1234;
      #1;
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL stall_hold_c%0d got=%h exp=%h", c, got_o, exp_o);
      end
    end
    stall_e = 0;
  endtask

  task automatic test_flush_over_stall();
    clear_inputs();
    d_valid = 1; d_rs = 2; d_rt = 3; d_rd1 = 5; d_rd2 = 6;
    d_memwrite = 1; d_regwrite = 1; d_alu_ctrl = 3'b010;
    sb.push_back(mk(5, 6, 6, 3'b010, 3, 1, 1, 0, 1, 2'b00, 2'b00));
    step(); #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL flush_setup got=%h exp=%h", got_o, exp_o);
    end
    stall_e = 1; flush_e = 1;
    sb.push_back(mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); #1;
    exp_o = sb.pop_front(); got_o = sample(); checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL flush_over_stall got=%h exp=%h", got_o, exp_o);
    end
    stall_e = 0; flush_e = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, im;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  ct;
    logic        as, rdst, rw, mr, mwr;
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      r1 = $urandom; r2 = $urandom; im = $urandom;
      rs = 5'($urandom_range(1, 31)); rt = 5'($urandom_range(1, 31));
      rd = 5'($urandom_range(0, 31)); ct = 3'($urandom_range(0, 7));
      as = 1'($urandom_range(0, 1)); rdst = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1));
      mwr = 1'($urandom_range(0, 1));
      d_valid = 1; d_rd1 = r1; d_rd2 = r2; d_imm = im; d_rs = rs; d_rt = rt; d_rd = rd;
      d_alu_ctrl = ct; d_alusrc = as; d_regdst = rdst;
      d_regwrite = rw; d_memtoreg = mr; d_memwrite = mwr;
      sb.push_back(mk(r1, as ? im : r2, r2, ct, rdst ? rd : rt, 1, rw, mr, mwr, 2'b00, 2'b00));
      step(); #1;
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL back_to_back_%0d got=%h exp=%h", i, got_o, exp_o);
      end
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_basic_load();
    test_forward_priority();
    test_reg0_imm();
    test_stall_retire();
    test_flush_over_stall();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-stage operand forwarding for the pipelined MIPS core.
- Captures decoded operands and control, resolves RAW hazards from MEM/WB, and drives the ALU's A, B and 3-bit ctrl inputs directly.
- Also supplies the forwarded store data and destination register to EX/MEM.

Parameters:
WIDTH, 32, datapath width
REGBITS, 5, register index width
CTRLW, 3, ALU control width (010 = add)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
stall_e  in  1  hold stage contents
flush_e  in  1  load bubble
d_valid  in  1  decode instruction valid
d_rd1  in  WIDTH  register file read A
d_rd2  in  WIDTH  register file read B
d_rs  in  REGBITS  source A index
d_rt  in  REGBITS  source B index
d_rd  in  REGBITS  R-type destination
d_imm  in  WIDTH  sign-extended immediate
d_alu_ctrl  in  CTRLW  ALU operation
d_alusrc  in  1  1 = B takes immediate
d_regdst  in  1  1 = destination is rd
d_regwrite  in  1  writes register file
d_memtoreg  in  1  load
d_memwrite  in  1  store
m_regwrite  in  1  MEM stage writes
m_writereg  in  REGBITS  MEM destination
m_aluout  in  WIDTH  MEM result
w_regwrite  in  1  WB stage writes
w_writereg  in  REGBITS  WB destination
w_result  in  WIDTH  WB result
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_ctrl  out  CTRLW  ALU control
e_writedata  out  WIDTH  forwarded rt value for stores
e_writereg  out  REGBITS  destination index
e_regwrite, e_memtoreg, e_memwrite  out  1 each  registered control
e_valid  out  1  stage holds a real instruction
fwd_a, fwd_b  out  2 each  00 = reg, 01 = WB, 10 = MEM

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Update priority at each rising edge of clk: reset > flush_e > stall_e > load.
- Load: all d_* inputs are registered, giving one-cycle latency.
- Reset: every register clears to 0.
  - alu_ctrl = 000, e_valid = 0, all control bits = 0.
  - alu_a/alu_b then follow the forwarding rules on zeroed operands.
- Flush: identical clear to reset, producing a bubble.
  - flush_e with stall_e: flush wins.
- Stall: rs/rt/rd/imm/ctrl are held.
  - The stored rd1/rd2 are overwritten with the currently forwarded values, so a producer retiring from WB during the stall is not lost.
- Forwarding (combinational on registered rs_e/rt_e), evaluated separately for each source:
  - fwd = 10 if m_regwrite, m_writereg != 0 and m_writereg == source index.
  - Else fwd = 01 if the same conditions hold for the WB stage (w_regwrite, w_writereg).
  - Else fwd = 00.
  - MEM has priority over WB. Register 0 is never forwarded and always reads the stored value.
- srcA/srcB selected per fwd code.
  - alu_a = srcA.
  - alu_b = srcB when alusrc_e = 0, imm_e when alusrc_e = 1.
  - e_writedata = srcB regardless of alusrc.
- e_writereg = rd_e when regdst_e = 1, else rt_e.
- No arithmetic here; widths are passed through unchanged.
- Invalid stage: e_valid = 0 implies all write/mem controls = 0.

Optional Feature:
- Macro: FWD_STATS_EN.
- Defined:
  - Adds output fwd_count (16 bits), a saturating count of clock cycles where e_valid = 1, stall_e = 0, and fwd_a or fwd_b is non-zero.
  - Cleared by reset only; holds at 0xFFFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - Forwarding codes FWD_REG, FWD_WB, FWD_MEM.
  - ALU control constants (ALU_ADD = 010 etc).
  - WIDTH/REGBITS defaults.
- One natural sub-module: forward_unit, the combinational comparator producing fwd_a/fwd_b, instantiated once. The stage register and muxes stay in the top.

Test Plan:
- Reset then idle: assert reset one cycle → e_valid = 0, alu_ctrl = 000, e_regwrite = 0, fwd_a = fwd_b = 00.
- Basic load: d_rd1 = 0, d_rd2 = 1, ctrl = 010, alusrc = 0, regdst = 1, rd = 8 → next cycle alu_a = 0, alu_b = 1, alu_ctrl = 010, e_writereg = 8.
- Forward priority: rs_e = 3, m_writereg = 3 (m_aluout = 0x55), w_writereg = 3 (w_result = 0x66), both regwrite → fwd_a = 10, alu_a = 0x55. Drop m_regwrite → fwd_a = 01, alu_a = 0x66.
- Register 0 and immediate: rs = 0, m_writereg = 0, m_regwrite = 1 → fwd_a = 00. alusrc = 1, imm = 0xFFFFFFFC, rt forwarded 0x77 → alu_b = 0xFFFFFFFC, e_writedata = 0x77.
- Stall and retire:
  - Stall 2 cycles with rt_e = 4 forwarded from WB (0x99) in cycle 1; WB moves on in cycle 2.
  - Required: alu_b stays 0x99 and fwd_b = 00 in cycle 2.
- Flush over stall: stall_e = flush_e = 1 → e_valid = 0, e_memwrite = 0 next cycle. With FWD_STATS_EN defined, fwd_count does not increment.
